// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word load/store at a time, inserts WAIT_STATES wait cycles,
// then accesses an internal synchronous RAM and reports completion with a one-cycle done pulse.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_write_en,
  input  logic [31:0] dmem_val_out,
  output logic [31:0] dmem_val_in,
  output logic        dmem_ready,
  output logic        dmem_done,
  output logic        dmem_err
);

  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_we;
  logic [31:0]           req_wdata;
  logic [31:0]           mem [Depth];

  logic addr_bad;
  logic access;

  // Misaligned, or any byte-address bit above the RAM's range set.
  assign addr_bad   = (dmem_addr[1:0] != 2'b00) || ((dmem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign access     = (state == StWait) && (wait_cnt == 4'd0);
  assign dmem_ready = (state == StIdle);

  // Gated by rst_n so a store whose access edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && access && req_we) begin
      mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StIdle;
      wait_cnt    <= 4'd0;
      req_idx     <= '0;
      req_we      <= 1'b0;
      req_wdata   <= 32'h0;
      dmem_val_in <= 32'h0;
      dmem_done   <= 1'b0;
      dmem_err    <= 1'b0;
    end else begin
      dmem_done <= 1'b0;
      dmem_err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (dmem_req) begin
            req_idx   <= dmem_addr[ADDR_WIDTH+1:2];
            req_we    <= dmem_write_en;
            req_wdata <= dmem_val_out;
            if (addr_bad) begin
              state     <= StDone;
              dmem_done <= 1'b1;
              dmem_err  <= 1'b1;
              if (!dmem_write_en) begin
                dmem_val_in <= 32'h0;
              end
            end else begin
              state    <= StWait;
              wait_cnt <= WaitInit;
            end
          end
        end
        StWait: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (!req_we) begin
              dmem_val_in <= mem[req_idx];
            end
            state     <= StDone;
            dmem_done <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
